// File: rtl/audio_frame_capture.sv
// Frame capture front end: fills an N-word buffer from a valid/ready sample stream,
// hands the frame to the analyzer with a start pulse and waits for its done edge.
module audio_frame_capture #(
    parameter int N          = 100,
    parameter int AW         = 7,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arm,
    input  logic          s_valid,
    input  logic [31:0]   s_data,
    output logic          s_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic          start,
    input  logic          done,
    output logic          busy,
    output logic [15:0]   frame_cnt,
    output logic          overrun
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HANDOFF,
        WAIT_DONE
    } state_t;

    state_t state, state_next;

    logic [AW-1:0] wr_ptr;
    logic          done_q;
    logic          accept;
    logic          last_accept;
    logic          done_rise;

    // Sized to the full address space so every rd_addr indexes a real word;
    // words at N and above simply hold stale contents.
    logic [31:0] mem [2**AW];

    assign s_ready     = (state == FILL);
    assign busy        = (state != IDLE);
    assign accept      = s_valid && s_ready;
    assign last_accept = accept && (wr_ptr == AW'(N - 1));
    assign done_rise   = done && !done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets its default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (arm) state_next = FILL;
            FILL:      if (last_accept) state_next = HANDOFF;
            HANDOFF:   state_next = WAIT_DONE;
            WAIT_DONE: if (done_rise) state_next = CONTINUOUS ? FILL : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            done_q    <= 1'b0;
            start     <= 1'b0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            done_q <= done;
            // start comes straight from a flop: high for the single HANDOFF cycle
            start  <= (state_next == HANDOFF);

            if (state_next == FILL && state != FILL)
                wr_ptr <= '0;
            else if (accept)
                wr_ptr <= wr_ptr + AW'(1);

            if (state == WAIT_DONE && done_rise)
                frame_cnt <= frame_cnt + 16'd1;

            if (!CONTINUOUS && state == IDLE && arm)
                overrun <= 1'b0;
            else if (s_valid && (state == HANDOFF || state == WAIT_DONE))
                overrun <= 1'b1;
        end
    end

    // NOTE: the buffer array has no reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= s_data;
    end

    // Same-address read during a write returns the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_data <= '0;
        else       rd_data <= mem[rd_addr];
    end

endmodule
